// File: rtl/tmr_mon_pkg.sv
// Shared types and helpers for the TMR error monitor: FSM encoding, popcount
// and a saturating adder whose width is passed in by the caller.
package tmr_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RESYNC  = 2'd2
  } mon_state_e;

  localparam int unsigned MAX_SRC = 64;

  // Only the low n bits of v are counted, so callers may zero-extend freely.
  function automatic logic [31:0] popcount(input logic [MAX_SRC-1:0] v, input int unsigned n);
    logic [31:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_SRC; i++)
      if (i < n && v[i]) c = c + 32'd1;
    return c;
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (65'd1 << w) - 65'd1;
    return (s > mx) ? mx[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/tmr_err_chan.sv
// One monitored err line: input/edge registers, rising-edge event, persistence
// counter and the sticky bit that software clears by acknowledging.
module tmr_err_chan
  import tmr_mon_pkg::*;
#(
  parameter int PERSIST = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic err,
  input  logic freeze,
  input  logic clr_prev,
  input  logic clr_sticky,
  output logic evt,
  output logic persist_hit,
  output logic sticky
);

  localparam int PW = $clog2(PERSIST + 1);

  logic          err_q;
  logic          err_prev;
  logic [PW-1:0] pcnt;

  assign evt         = err_q & ~err_prev;
  assign persist_hit = (int'(pcnt) + int'(err_q)) >= PERSIST;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      err_prev <= 1'b0;
      pcnt     <= '0;
      sticky   <= 1'b0;
    end else begin
      err_q    <= err;
      // Forgetting the previous sample makes a still-high line re-fire after resync.
      err_prev <= clr_prev ? 1'b0 : err_q;

      if (freeze || !err_q)
        pcnt <= '0;
      else if (pcnt != PW'(PERSIST))
        pcnt <= pcnt + 1'b1;

      if (freeze)
        sticky <= clr_sticky ? 1'b0 : sticky;
      else
        sticky <= (clr_sticky ? 1'b0 : sticky) | err_q;
    end
  end

endmodule

// File: rtl/tmr_err_monitor.sv
// Collects the err lines of triplicated logic: counts disagreement events,
// raises an interrupt for software and requests a replica resync on persistence.
module tmr_err_monitor
  import tmr_mon_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int CNT_W   = 16,
  parameter int PERSIST = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] err_i,
  input  logic             ack_i,
  input  logic             cnt_clr_i,
  output logic             irq_o,
  output logic [N_SRC-1:0] sticky_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             resync_req_o,
  input  logic             resync_done_i
);

  mon_state_e       state;
  logic [N_SRC-1:0] evt;
  logic [N_SRC-1:0] hit;
  logic [31:0]      pc;
  logic             hit_any;
  logic             evt_any;
  logic             freeze;
  logic             clr_prev;
  logic             clr_sticky;

  assign hit_any    = |hit;
  assign evt_any    = |evt;
  assign pc         = popcount(64'(evt), N_SRC);
  assign freeze     = (state == RESYNC);
  assign clr_prev   = freeze & resync_done_i;
  // Ack only clears when it is actually accepted, i.e. not pre-empted by a resync.
  assign clr_sticky = clr_prev | ((state == PENDING) & ~hit_any & ack_i);

  for (genvar g = 0; g < N_SRC; g++) begin : g_chan
    tmr_err_chan #(.PERSIST(PERSIST)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .err        (err_i[g]),
      .freeze     (freeze),
      .clr_prev   (clr_prev),
      .clr_sticky (clr_sticky),
      .evt        (evt[g]),
      .persist_hit(hit[g]),
      .sticky     (sticky_o[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count_o <= '0;
    else
      err_count_o <= CNT_W'(sat_add(cnt_clr_i ? 64'd0 : 64'(err_count_o), 64'(pc), CNT_W));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      irq_o        <= 1'b0;
      resync_req_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit_any) begin
            state        <= RESYNC;
            resync_req_o <= 1'b1;
          end else if (evt_any) begin
            state <= PENDING;
            irq_o <= 1'b1;
          end
        end
        PENDING: begin
          if (hit_any) begin
            state        <= RESYNC;
            irq_o        <= 1'b0;
            resync_req_o <= 1'b1;
          end else if (ack_i) begin
            state <= IDLE;
            irq_o <= 1'b0;
          end
        end
        RESYNC: begin
          if (resync_done_i) begin
            state        <= IDLE;
            resync_req_o <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          irq_o        <= 1'b0;
          resync_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_err_monitor.sv
// Directed bench: stimulus pushes hand-computed expected outputs per cycle,
// a monitor pops and compares one entry after every rising edge.
module tb_tmr_err_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] err_i = 4'hF;
  logic       ack_i = 1'b0;
  logic       cnt_clr_i = 1'b0;
  logic       irq_o;
  logic [3:0] sticky_o;
  logic [3:0] err_count_o;
  logic       resync_req_o;
  logic       resync_done_i = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    bit         chk;
    logic       irq;
    logic       rsy;
    logic [3:0] stk;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  tmr_err_monitor #(.N_SRC(4), .CNT_W(4), .PERSIST(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .err_i        (err_i),
    .ack_i        (ack_i),
    .cnt_clr_i    (cnt_clr_i),
    .irq_o        (irq_o),
    .sticky_o     (sticky_o),
    .err_count_o  (err_count_o),
    .resync_req_o (resync_req_o),
    .resync_done_i(resync_done_i)
  );

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] e, input logic a, input logic c, input logic d,
                      input logic r, input string nm, input bit chk, input logic irq,
                      input logic rsy, input logic [3:0] stk, input logic [3:0] cnt);
    exp_t x;
    @(negedge clk);
    err_i = e; ack_i = a; cnt_clr_i = c; resync_done_i = d; rst_n = r;
    x.nm = nm; x.chk = chk; x.irq = irq; x.rsy = rsy; x.stk = stk; x.cnt = cnt;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.chk) begin
          checks++;
          if (irq_o !== x.irq || resync_req_o !== x.rsy || sticky_o !== x.stk ||
              err_count_o !== x.cnt) begin
            errors++;
            $display("FAIL %s: got irq=%b rsy=%b sticky=%b cnt=%0d, want irq=%b rsy=%b sticky=%b cnt=%0d",
                     x.nm, irq_o, resync_req_o, sticky_o, err_count_o,
                     x.irq, x.rsy, x.stk, x.cnt);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset with all err lines high, released while they are still high.
    step(4'hF, 0, 0, 0, 0, "rst0",      1, 0, 0, 4'b0000, 4'd0);
    step(4'hF, 0, 0, 0, 0, "rst1",      1, 0, 0, 4'b0000, 4'd0);
    step(4'hF, 0, 0, 0, 1, "rst_rel",   1, 0, 0, 4'b0000, 4'd0);
    step(4'h0, 0, 0, 0, 1, "post_rel",  1, 1, 0, 4'b1111, 4'd4);
    step(4'h0, 1, 0, 0, 1, "post_ack",  1, 0, 0, 4'b0000, 4'd4);
    step(4'h0, 0, 1, 0, 1, "post_clr",  1, 0, 0, 4'b0000, 4'd0);

    // Single-cycle glitch on source 1.
    step(4'b0010, 0, 0, 0, 1, "gl_in",   1, 0, 0, 4'b0000, 4'd0);
    step(4'b0000, 0, 0, 0, 1, "gl_irq",  1, 1, 0, 4'b0010, 4'd1);
    step(4'b0000, 0, 0, 0, 1, "gl_hold", 1, 1, 0, 4'b0010, 4'd1);
    step(4'b0000, 1, 0, 0, 1, "gl_ack",  1, 0, 0, 4'b0000, 4'd1);
    step(4'b0000, 1, 0, 1, 1, "gl_stray",1, 0, 0, 4'b0000, 4'd1);

    // Saturation of the 4-bit counter with 20 isolated pulses.
    step(4'b0000, 0, 1, 0, 1, "sat_clr", 1, 0, 0, 4'b0000, 4'd0);
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, 0, 0, 0, 1, "sat_hi", 0, 0, 0, 4'b0000, 4'd0);
      step(4'b0000, 0, 0, 0, 1, "sat_lo", 1, 1, 0, 4'b0001,
           (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    end
    step(4'b0101, 0, 0, 0, 1, "sat_pre", 1, 1, 0, 4'b0001, 4'd15);
    step(4'b0000, 0, 1, 0, 1, "clr_evt", 1, 1, 0, 4'b0101, 4'd2);
    step(4'b0000, 1, 0, 0, 1, "clr_ack", 1, 0, 0, 4'b0000, 4'd2);

    // Persistent source 3: PENDING, then RESYNC, then fresh event after done.
    step(4'b1000, 0, 0, 0, 1, "ps_e1",   1, 0, 0, 4'b0000, 4'd2);
    step(4'b1000, 0, 0, 0, 1, "ps_e2",   1, 1, 0, 4'b1000, 4'd3);
    step(4'b1000, 0, 0, 0, 1, "ps_e3",   1, 1, 0, 4'b1000, 4'd3);
    step(4'b1000, 1, 0, 0, 1, "ps_e4",   1, 0, 1, 4'b1000, 4'd3);
    step(4'b1000, 0, 0, 0, 1, "ps_hold", 1, 0, 1, 4'b1000, 4'd3);
    step(4'b1000, 1, 0, 0, 1, "ps_ack",  1, 0, 1, 4'b1000, 4'd3);
    step(4'b1000, 0, 0, 1, 1, "ps_done", 1, 0, 0, 4'b0000, 4'd3);
    step(4'b1000, 0, 0, 0, 1, "ps_refire",1, 1, 0, 4'b1000, 4'd4);
    step(4'b0000, 0, 0, 0, 1, "ps_drop", 1, 1, 0, 4'b1000, 4'd4);
    step(4'b0000, 1, 0, 0, 1, "ps_clear",1, 0, 0, 4'b0000, 4'd4);

    // Two sources rising together; ack while source 0 is still sampled high.
    step(4'b0101, 0, 0, 0, 1, "sim_in",  1, 0, 0, 4'b0000, 4'd4);
    step(4'b0001, 0, 0, 0, 1, "sim_evt", 1, 1, 0, 4'b0101, 4'd6);
    step(4'b0000, 1, 0, 0, 1, "sim_ack", 1, 0, 0, 4'b0001, 4'd6);
    step(4'b0000, 0, 0, 0, 1, "sim_idle",1, 0, 0, 4'b0001, 4'd6);

    // Reset while in RESYNC; a later done must not matter.
    step(4'b1000, 0, 0, 0, 1, "rz_e1",   1, 0, 0, 4'b0001, 4'd6);
    step(4'b1000, 0, 0, 0, 1, "rz_e2",   1, 1, 0, 4'b1001, 4'd7);
    step(4'b1000, 0, 0, 0, 1, "rz_e3",   1, 1, 0, 4'b1001, 4'd7);
    step(4'b1000, 0, 0, 0, 1, "rz_e4",   1, 0, 1, 4'b1001, 4'd7);
    step(4'b1000, 0, 0, 0, 0, "rz_rst",  1, 0, 0, 4'b0000, 4'd0);
    step(4'b0000, 0, 0, 1, 1, "rz_done1",1, 0, 0, 4'b0000, 4'd0);
    step(4'b0000, 0, 0, 1, 1, "rz_done2",1, 0, 0, 4'b0000, 4'd0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
